// File: rtl/snake_tile_renderer.sv
// snake_tile_renderer: builds a double-buffered tile occupancy bitmap from the snake segment list
// once per frame and overlays head/body/food on the palette colour. Grid lines: SNAKE_GRID_LINES_EN.
module snake_tile_renderer #(
  parameter int unsigned GRID_W       = 10,
  parameter int unsigned GRID_H       = 10,
  parameter int unsigned TILE_SIZE    = 40,
  parameter int unsigned BOARD_X0     = 48,
  parameter int unsigned BOARD_Y0     = 48,
  parameter int unsigned MAX_SEGMENTS = 100,
  parameter int unsigned COORD_W      = 32,
  parameter logic [11:0] HEAD_COLOR   = 12'hFF0,
  parameter logic [11:0] FOOD_COLOR   = 12'hF00
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            frame_start,
  input  logic [MAX_SEGMENTS*COORD_W-1:0] seg_x,
  input  logic [MAX_SEGMENTS*COORD_W-1:0] seg_y,
  input  logic [COORD_W-1:0]              food_x,
  input  logic [COORD_W-1:0]              food_y,
  input  logic                            color_advance,
  input  logic                            pix_valid,
  input  logic [9:0]                      pix_x,
  input  logic [9:0]                      pix_y,
  input  logic [11:0]                     bg_color,
  output logic                            out_valid,
  output logic [11:0]                     out_color,
  output logic                            build_busy,
  output logic [7:0]                      seg_count,
  output logic                            coord_err,
  output logic [7:0]                      drop_count
);

  localparam int unsigned CELLS    = GRID_W * GRID_H;
  localparam int unsigned CELL_W   = (CELLS > 1) ? $clog2(CELLS) : 1;
  localparam int unsigned IDX_W    = (MAX_SEGMENTS > 1) ? $clog2(MAX_SEGMENTS) : 1;
  localparam int unsigned TX_W     = (GRID_W > 1) ? $clog2(GRID_W) : 1;
  localparam int unsigned TY_W     = (GRID_H > 1) ? $clog2(GRID_H) : 1;
  localparam int unsigned BOARD_X1 = BOARD_X0 + GRID_W * TILE_SIZE;
  localparam int unsigned BOARD_Y1 = BOARD_Y0 + GRID_H * TILE_SIZE;
  localparam logic [COORD_W-1:0] SENTINEL   = {COORD_W{1'b1}};
  localparam logic [11:0]        BODY_RESET = 12'h0F0;
`ifdef SNAKE_GRID_LINES_EN
  localparam logic [11:0]        GRID_COLOR = 12'h333;
`endif

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_SCAN, S_DONE} state_t;

  state_t state, state_nxt;

  // Snapshot of the segment list and food, taken when a build starts
  logic [COORD_W-1:0] snap_x [MAX_SEGMENTS];
  logic [COORD_W-1:0] snap_y [MAX_SEGMENTS];
  logic [COORD_W-1:0] snap_food_x, snap_food_y;

  logic [IDX_W-1:0]   idx;
  logic [CELLS-1:0]   bm_a, bm_b;
  logic               front_sel;
  logic [7:0]         back_cnt;
  logic [TX_W-1:0]    back_head_x, front_head_x;
  logic [TY_W-1:0]    back_head_y, front_head_y;
  logic               back_head_vld, front_head_vld;
  logic [COORD_W-1:0] front_food_x, front_food_y;
  logic [11:0]        body_color;

  // FSM control strobes
  logic snap_en, swap_en, clear_en, mark_en, err_en, drop_en, busy_nxt;

  // Current scan slot decode
  logic [COORD_W-1:0] cur_x, cur_y;
  logic               cur_sent, cur_in_range, last_slot;
  logic [CELL_W-1:0]  cur_cell;

  always_comb begin
    cur_x        = snap_x[idx];
    cur_y        = snap_y[idx];
    cur_sent     = (cur_x == SENTINEL) || (cur_y == SENTINEL);
    cur_in_range = (cur_x < COORD_W'(GRID_W)) && (cur_y < COORD_W'(GRID_H));
    last_slot    = (idx == IDX_W'(MAX_SEGMENTS - 1));
    cur_cell     = CELL_W'(cur_y) * CELL_W'(GRID_W) + CELL_W'(cur_x);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    snap_en   = 1'b0;
    swap_en   = 1'b0;
    clear_en  = 1'b0;
    mark_en   = 1'b0;
    err_en    = 1'b0;
    drop_en   = 1'b0;
    case (state)
      S_IDLE: begin
        if (frame_start) begin
          snap_en   = 1'b1;
          state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        clear_en  = 1'b1;
        drop_en   = frame_start;
        state_nxt = S_SCAN;
      end
      S_SCAN: begin
        drop_en = frame_start;
        if (cur_sent) begin
          state_nxt = S_DONE;
        end else begin
          mark_en = cur_in_range;
          err_en  = !cur_in_range;
          if (last_slot) state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (frame_start) begin
          swap_en   = 1'b1;
          snap_en   = 1'b1;
          state_nxt = S_CLEAR;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    busy_nxt = (state_nxt == S_CLEAR) || (state_nxt == S_SCAN);
  end

  // Snapshot registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(MAX_SEGMENTS); i++) begin
        snap_x[i] <= '0;
        snap_y[i] <= '0;
      end
      snap_food_x <= '0;
      snap_food_y <= '0;
    end else if (snap_en) begin
      for (int i = 0; i < int'(MAX_SEGMENTS); i++) begin
        snap_x[i] <= seg_x[i*COORD_W +: COORD_W];
        snap_y[i] <= seg_y[i*COORD_W +: COORD_W];
      end
      snap_food_x <= food_x;
      snap_food_y <= food_y;
    end
  end

  // Back-buffer build: the buffer not selected by front_sel is cleared then filled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx           <= '0;
      bm_a          <= '0;
      bm_b          <= '0;
      back_cnt      <= '0;
      back_head_x   <= '0;
      back_head_y   <= '0;
      back_head_vld <= 1'b0;
    end else begin
      if (clear_en) begin
        idx           <= '0;
        back_cnt      <= '0;
        back_head_vld <= 1'b0;
        if (front_sel) bm_a <= '0;
        else           bm_b <= '0;
      end
      if (mark_en || err_en) idx <= idx + IDX_W'(1);
      if (mark_en) begin
        if (front_sel) bm_a[cur_cell] <= 1'b1;
        else           bm_b[cur_cell] <= 1'b1;
        if (back_cnt != 8'hFF) back_cnt <= back_cnt + 8'd1;
        if (idx == '0) begin
          back_head_x   <= TX_W'(cur_x);
          back_head_y   <= TY_W'(cur_y);
          back_head_vld <= 1'b1;
        end
      end
    end
  end

  // Front-side state only changes on a swap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      front_sel      <= 1'b0;
      front_head_x   <= '0;
      front_head_y   <= '0;
      front_head_vld <= 1'b0;
      front_food_x   <= '0;
      front_food_y   <= '0;
      seg_count      <= '0;
    end else if (swap_en) begin
      front_sel      <= !front_sel;
      front_head_x   <= back_head_x;
      front_head_y   <= back_head_y;
      front_head_vld <= back_head_vld;
      front_food_x   <= snap_food_x;
      front_food_y   <= snap_food_y;
      seg_count      <= back_cnt;
    end
  end

  // Status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      build_busy <= 1'b0;
      coord_err  <= 1'b0;
      drop_count <= '0;
    end else begin
      build_busy <= busy_nxt;
      if (err_en) coord_err <= 1'b1;
      if (drop_en && (drop_count != 8'hFF)) drop_count <= drop_count + 8'd1;
    end
  end

  // Body colour nibble rotation; an all-zero result is replaced by blue
  logic [11:0] body_rot;
  always_comb body_rot = {body_color[7:0], body_color[11:8]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) body_color <= BODY_RESET;
    else if (color_advance) body_color <= (body_rot == 12'h000) ? 12'h00F : body_rot;
  end

  // Pixel stage 1: board test and tile coordinates
  logic [9:0]      px_rel, py_rel;
  logic            in_board_c;
  logic [TX_W-1:0] tx_c;
  logic [TY_W-1:0] ty_c;

  always_comb begin
    px_rel     = pix_x - 10'(BOARD_X0);
    py_rel     = pix_y - 10'(BOARD_Y0);
    in_board_c = (32'(pix_x) >= BOARD_X0) && (32'(pix_x) < BOARD_X1) &&
                 (32'(pix_y) >= BOARD_Y0) && (32'(pix_y) < BOARD_Y1);
    tx_c       = TX_W'(32'(px_rel) / TILE_SIZE);
    ty_c       = TY_W'(32'(py_rel) / TILE_SIZE);
  end

  logic            s1_valid, s1_in_board;
  logic [TX_W-1:0] s1_tx;
  logic [TY_W-1:0] s1_ty;
  logic [11:0]     s1_bg;
`ifdef SNAKE_GRID_LINES_EN
  logic            s1_grid;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid    <= 1'b0;
      s1_in_board <= 1'b0;
      s1_tx       <= '0;
      s1_ty       <= '0;
      s1_bg       <= '0;
`ifdef SNAKE_GRID_LINES_EN
      s1_grid     <= 1'b0;
`endif
    end else begin
      s1_valid    <= pix_valid;
      s1_in_board <= in_board_c;
      s1_tx       <= tx_c;
      s1_ty       <= ty_c;
      s1_bg       <= bg_color;
`ifdef SNAKE_GRID_LINES_EN
      s1_grid     <= ((32'(px_rel) % TILE_SIZE) == 32'd0) ||
                     ((32'(py_rel) % TILE_SIZE) == 32'd0);
`endif
    end
  end

  // Pixel stage 2: priority overlay head > body > food > background
  logic [CELLS-1:0]  front_bm_c;
  logic [CELL_W-1:0] s1_cell;
  logic              head_hit, body_hit, food_hit;
  logic [11:0]       pix_col;

  always_comb begin
    front_bm_c = front_sel ? bm_b : bm_a;
    s1_cell    = CELL_W'(s1_ty) * CELL_W'(GRID_W) + CELL_W'(s1_tx);
    head_hit   = front_head_vld && (s1_tx == front_head_x) && (s1_ty == front_head_y);
    body_hit   = front_bm_c[s1_cell];
    food_hit   = (front_food_x == COORD_W'(s1_tx)) && (front_food_y == COORD_W'(s1_ty));
    pix_col    = s1_bg;
    if (s1_in_board) begin
      if (head_hit)      pix_col = HEAD_COLOR;
      else if (body_hit) pix_col = body_color;
      else if (food_hit) pix_col = FOOD_COLOR;
`ifdef SNAKE_GRID_LINES_EN
      else if (s1_grid)  pix_col = GRID_COLOR;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_color <= '0;
    end else begin
      out_valid <= s1_valid;
      out_color <= s1_valid ? pix_col : 12'h000;
    end
  end

endmodule

// File: tb/tb_snake_tile_renderer.sv
// Bench for snake_tile_renderer: directed + random stimulus against a list-level reference model,
// with a queue-based scoreboard checked by an independent output monitor.
`timescale 1ns/1ps
module tb_snake_tile_renderer;
  localparam int GW = 10, GH = 10, TS = 40, X0 = 48, Y0 = 48, MS = 100, CW = 32;
  localparam logic [11:0] HEAD = 12'hFF0, FOOD = 12'hF00;
  localparam logic [31:0] SENT = 32'hFFFF_FFFF;
  localparam int NEVER = 32'h7FFF_FFFF;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              frame_start = 1'b0;
  logic [MS*CW-1:0]  seg_x = '0, seg_y = '0;
  logic [CW-1:0]     food_x = '0, food_y = '0;
  logic              color_advance = 1'b0;
  logic              pix_valid = 1'b0;
  logic [9:0]        pix_x = '0, pix_y = '0;
  logic [11:0]       bg_color = '0;
  logic              out_valid;
  logic [11:0]       out_color;
  logic              build_busy;
  logic [7:0]        seg_count;
  logic              coord_err;
  logic [7:0]        drop_count;

  snake_tile_renderer dut (
    .clk(clk), .reset(reset), .frame_start(frame_start),
    .seg_x(seg_x), .seg_y(seg_y), .food_x(food_x), .food_y(food_y),
    .color_advance(color_advance), .pix_valid(pix_valid),
    .pix_x(pix_x), .pix_y(pix_y), .bg_color(bg_color),
    .out_valid(out_valid), .out_color(out_color), .build_busy(build_busy),
    .seg_count(seg_count), .coord_err(coord_err), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;

  // Scoreboard
  logic [11:0] exp_col_q [$];
  int          exp_cyc_q [$];

  // Stimulus-side lists
  logic [31:0] lx [MS];
  logic [31:0] ly [MS];
  logic [31:0] fx, fy;

  // Reference model: displayed frame (f_*), frame being built (b_*)
  bit [GW*GH-1:0] f_cells, b_cells;
  int          f_hx, f_hy, b_hx, b_hy, b_cnt;
  bit          f_hv, b_hv;
  logic [31:0] f_fx, f_fy, b_fx, b_fy;
  int          m_seg, m_drop, m_cerr_at, m_bstart, m_bend, m_body;
  bit          m_started;
  logic [11:0] body_tab [3];

  initial begin
    body_tab[0] = 12'h0F0;
    body_tab[1] = 12'hF00;
    body_tab[2] = 12'h00F;
  end

  task automatic model_reset();
    f_cells = '0; b_cells = '0;
    f_hv = 0; b_hv = 0; f_hx = 0; f_hy = 0; b_hx = 0; b_hy = 0; b_cnt = 0;
    f_fx = '0; f_fy = '0; b_fx = '0; b_fy = '0;
    m_seg = 0; m_drop = 0; m_cerr_at = NEVER; m_bstart = 0; m_bend = 0; m_body = 0;
    m_started = 0;
  endtask

  // A frame_start seen at clock edge e
  task automatic model_frame(input int e);
    int n;
    if (m_started && e <= m_bend + 1) begin
      if (m_drop < 255) m_drop++;
      return;
    end
    if (m_started) begin
      f_cells = b_cells; f_hv = b_hv; f_hx = b_hx; f_hy = b_hy;
      f_fx = b_fx; f_fy = b_fy; m_seg = b_cnt;
    end
    m_started = 1;
    b_cells = '0; b_cnt = 0; b_hv = 0; n = 0;
    for (int k = 0; k < MS; k++) begin
      n++;
      if (lx[k] == SENT || ly[k] == SENT) break;
      if (lx[k] >= GW || ly[k] >= GH) begin
        if (e + 2 + k < m_cerr_at) m_cerr_at = e + 2 + k;
      end else begin
        b_cells[int'(ly[k]) * GW + int'(lx[k])] = 1'b1;
        b_cnt++;
        if (k == 0) begin b_hv = 1; b_hx = int'(lx[0]); b_hy = int'(ly[0]); end
      end
    end
    b_fx = fx; b_fy = fy;
    m_bstart = e; m_bend = e + n;
  endtask

  function automatic logic [11:0] model_pixel(input int px, input int py, input logic [11:0] bg);
    int tx, ty;
    if (px < X0 || px >= X0 + GW*TS || py < Y0 || py >= Y0 + GH*TS) return bg;
    tx = (px - X0) / TS;
    ty = (py - Y0) / TS;
    if (f_hv && tx == f_hx && ty == f_hy) return HEAD;
    if (f_cells[ty*GW + tx]) return body_tab[m_body];
    if (f_fx == 32'(tx) && f_fy == 32'(ty)) return FOOD;
`ifdef SNAKE_GRID_LINES_EN
    if ((px - X0) % TS == 0 || (py - Y0) % TS == 0) return 12'h333;
`endif
    return bg;
  endfunction

  task automatic chk(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic check_status();
    chk("seg_count", int'(seg_count), m_seg);
    chk("drop_count", int'(drop_count), m_drop);
    chk("coord_err", int'(coord_err), (cyc >= m_cerr_at) ? 1 : 0);
    chk("build_busy", int'(build_busy), (m_started && cyc >= m_bstart && cyc <= m_bend) ? 1 : 0);
  endtask

  task automatic apply_lists();
    for (int k = 0; k < MS; k++) begin
      seg_x[k*CW +: CW] = lx[k];
      seg_y[k*CW +: CW] = ly[k];
    end
    food_x = fx;
    food_y = fy;
  endtask

  // One clock of stimulus; called at a falling edge
  task automatic step(input bit fs, input bit ca, input bit pv, input int px, input int py,
                      input logic [11:0] bg);
    check_status();
    if (fs) model_frame(cyc + 1);
    if (ca) m_body = (m_body + 1) % 3;
    if (pv) begin
      exp_col_q.push_back(model_pixel(px, py, bg));
      exp_cyc_q.push_back(cyc + 2);
    end
    frame_start = fs; color_advance = ca; pix_valid = pv;
    pix_x = 10'(px); pix_y = 10'(py); bg_color = bg;
    @(negedge clk);
  endtask

  function automatic int rx();
    return ($urandom_range(0, 9) < 8) ? int'($urandom_range(X0, X0 + GW*TS - 1)) : int'($urandom_range(0, 1023));
  endfunction
  function automatic int ry();
    return ($urandom_range(0, 9) < 8) ? int'($urandom_range(Y0, Y0 + GH*TS - 1)) : int'($urandom_range(0, 1023));
  endfunction

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 12'($urandom));
  endtask
  task automatic pix(input int px, input int py);
    step(0, 0, 1, px, py, 12'($urandom));
  endtask
  task automatic rpix(input int n);
    repeat (n) step(0, 0, 1, rx(), ry(), 12'($urandom));
  endtask
  task automatic frame(input int w);
    step(1, 0, 0, 0, 0, 12'h000);
    idle(w);
  endtask

  task automatic clear_lists();
    for (int k = 0; k < MS; k++) begin lx[k] = SENT; ly[k] = SENT; end
  endtask

  task automatic rand_lists();
    int len;
    len = int'($urandom_range(0, MS));
    clear_lists();
    for (int k = 0; k < len; k++) begin
      lx[k] = ($urandom_range(0, 19) == 0) ? 32'($urandom_range(GW, GW + 5)) : 32'($urandom_range(0, GW - 1));
      ly[k] = ($urandom_range(0, 19) == 0) ? 32'($urandom_range(GH, GH + 5)) : 32'($urandom_range(0, GH - 1));
    end
    if (len < MS && $urandom_range(0, 1) == 0) lx[len] = 32'($urandom_range(0, GW - 1));
    fx = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(GW, 40)) : 32'($urandom_range(0, GW - 1));
    fy = 32'($urandom_range(0, GH - 1));
    apply_lists();
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_color", int'(out_color), 0);
    chk("reset_build_busy", int'(build_busy), 0);
    chk("reset_seg_count", int'(seg_count), 0);
    chk("reset_coord_err", int'(coord_err), 0);
    chk("reset_drop_count", int'(drop_count), 0);
    frame_start = 0; color_advance = 0; pix_valid = 0;
    model_reset();
    exp_col_q.delete();
    exp_cyc_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Output monitor: every presented pixel must match the oldest expectation at its due cycle
  always @(negedge clk) begin
    if (!reset) begin
      n_cmp++;
      if (out_valid) begin
        if (exp_col_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_pixel: out_valid=1 color=%h with nothing outstanding (cycle %0d)", out_color, cyc);
        end else begin
          logic [11:0] ec;
          int ecy;
          ec  = exp_col_q.pop_front();
          ecy = exp_cyc_q.pop_front();
          if (out_color !== ec || cyc != ecy) begin
            n_bad++;
            $display("FAIL pixel: got %h at cycle %0d, want %h at cycle %0d", out_color, cyc, ec, ecy);
          end
        end
      end else if (out_color !== 12'h000) begin
        n_bad++;
        $display("FAIL idle_color: out_color=%h while out_valid=0, want 000 (cycle %0d)", out_color, cyc);
      end
    end
  end

  initial begin
    model_reset();
    clear_lists();
    fx = 32'd20; fy = 32'd20;
    apply_lists();
    @(negedge clk);
    do_reset();

    // Two-segment snake; first frame builds, second displays
    lx[0] = 2; ly[0] = 3; lx[1] = 3; ly[1] = 3;
    apply_lists();
    frame(6);
    frame(6);
    pix(128, 168); pix(168, 168); pix(10, 10); pix(447, 447); pix(448, 100);
    idle(3);

    // Food at (5,5), then head moved onto it
    fx = 5; fy = 5; apply_lists();
    frame(6); frame(6);
    pix(248, 248); pix(168, 168); idle(2);
    lx[0] = 5; ly[0] = 5; apply_lists();
    frame(6); frame(6);
    pix(248, 248); pix(128, 168); idle(2);

    // Out-of-range slot is skipped but the rest are drawn
    lx[1] = 12; ly[1] = 3; lx[2] = 4; ly[2] = 4; apply_lists();
    frame(8); frame(8);
    pix(208, 208); pix(168, 168); rpix(10); idle(2);

    // Body colour rotation, including the blue-to-green wrap
    clear_lists();
    lx[0] = 2; ly[0] = 3; lx[1] = 3; ly[1] = 3; lx[2] = 4; ly[2] = 3;
    apply_lists();
    frame(6); frame(6);
    for (int i = 0; i < 4; i++) begin
      pix(168, 168);
      step(0, 1, 1, 208, 168, 12'h000);
      pix(208, 168);
    end
    idle(2);

    // Full list; a mid-build frame_start is dropped and the front stays put
    for (int k = 0; k < MS; k++) begin lx[k] = 32'(k % GW); ly[k] = 32'(k / GW); end
    apply_lists();
    frame(49);
    step(1, 0, 1, rx(), ry(), 12'($urandom));
    rpix(60);
    frame(0);
    rpix(110);
    frame(110);
    rpix(20);

    // Reset in the middle of a scan, then rebuild
    frame(10);
    do_reset();
    clear_lists();
    lx[0] = 1; ly[0] = 1; lx[1] = 2; ly[1] = 1; fx = 7; fy = 7;
    apply_lists();
    rpix(5);
    frame(6); frame(6);
    pix(88, 88); pix(128, 88); pix(328, 328); rpix(10);

    // Random traffic
    rand_lists();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) == 0) rand_lists();
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
           rx(), ry(), 12'($urandom));
    end

    idle(5);
    chk("scoreboard_drained", exp_col_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
